// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks the destinations of in-flight instructions in the
// EXE and MEM stages and raises a stall for the ID instruction on a RAW hazard.
// Build option: define FORWARDING_EN to stall only on EXE-stage load-use
// hazards (a forwarding unit covers every other dependency).
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        two_src,
    input  logic [3:0]  id_dest,
    input  logic        id_wb_en,
    input  logic        id_mem_read,
    output logic        hazard,
    output logic [3:0]  exe_dest,
    output logic [3:0]  mem_dest,
    output logic        exe_wb_en,
    output logic        mem_wb_en,
    output logic [15:0] stall_count
);

    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic             wb_en;
        logic [REG_W-1:0] dest;
        logic             mem_read;
    } slot_t;

    slot_t            exe_q, exe_d;
    slot_t            mem_q, mem_d;
    slot_t            id_slot;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             exe_match;
    logic             unused_slot_bits;

    // A slot matches when it will write a register the ID instruction reads
    function automatic logic slot_match(input slot_t s,
                                        input logic [REG_W-1:0] a,
                                        input logic [REG_W-1:0] b,
                                        input logic use_b);
        return s.wb_en && ((s.dest == a) || (use_b && (s.dest == b)));
    endfunction

    assign id_slot = '{wb_en: id_wb_en, dest: id_dest, mem_read: id_mem_read};

    // Stall decision from the ID operands against the pending slots
`ifdef FORWARDING_EN
    always_comb begin
        exe_match = slot_match(exe_q, src1, src2, two_src);
        hazard    = 1'b0;
        if (!flush && exe_match && exe_q.mem_read) begin
            hazard = 1'b1;
        end
    end
`else
    logic mem_match;

    always_comb begin
        exe_match = slot_match(exe_q, src1, src2, two_src);
        mem_match = slot_match(mem_q, src1, src2, two_src);
        hazard    = 1'b0;
        if (!flush && (exe_match || mem_match)) begin
            hazard = 1'b1;
        end
    end
`endif

    // Advance the slots; a stalled or squashed ID instruction enters EXE as a bubble
    always_comb begin
        mem_d         = exe_q;
        exe_d         = id_slot;
        stall_count_d = stall_count_q;
        if (hazard || flush) begin
            exe_d = '0;
        end
        if (hazard && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Slot and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q         <= '0;
            mem_q         <= '0;
            stall_count_q <= '0;
        end else begin
            exe_q         <= exe_d;
            mem_q         <= mem_d;
            stall_count_q <= stall_count_d;
        end
    end

    // mem_read is carried for completeness but only EXE's copy can feed the stall
    assign unused_slot_bits = ^{exe_q.mem_read, mem_q.mem_read};

    assign exe_dest    = exe_q.dest;
    assign exe_wb_en   = exe_q.wb_en;
    assign mem_dest    = mem_q.dest;
    assign mem_wb_en   = mem_q.wb_en;
    assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk is the single clock, rst is the synchronous active-high reset sampled on the rising edge of clk.
REQ-002 Port: clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: flush  input  1  branch taken; the instruction currently in ID is squashed.
REQ-005 Port: src1  input  4  ID-stage first source register number.
REQ-006 Port: src2  input  4  ID-stage second source register number; Rm, or Rd for stores.
REQ-007 Port: two_src  input  1  ID instruction reads src2.
REQ-008 Port: id_dest  input  4  ID-stage destination register.
REQ-009 Port: id_wb_en  input  1  ID instruction writes id_dest; already zeroed when its condition fails.
REQ-010 Port: id_mem_read  input  1  ID instruction is a load.
REQ-011 Port: hazard  output  1  stall request to IF/ID; combinational from inputs and slots.
REQ-012 Port: exe_dest, mem_dest  output  4 each  destination tags held in the EXE and MEM slots.
REQ-013 Port: exe_wb_en, mem_wb_en  output  1 each  slot-valid write flags.
REQ-014 Port: stall_count  output  16  count of stall cycles.

Function
REQ-015 The block SHALL hold two tracking slots, EXE and MEM; each slot is {wb_en, dest[3:0], mem_read}.
REQ-016 Each rising edge with rst low SHALL load the MEM slot from the EXE slot.
REQ-017 On that same edge the EXE slot SHALL load {id_wb_en, id_dest, id_mem_read}, or all-zero (a bubble) when hazard=1 or flush=1.
REQ-018 A WB-stage write SHALL be treated as visible to the same-cycle ID read, because the register file writes before ID samples; the block therefore has no WB slot.
REQ-019 The block SHALL define a slot match on s as: slot.wb_en=1 and slot.dest=src1, or slot.wb_en=1 and two_src=1 and slot.dest=src2.
REQ-020 Without FORWARDING_EN, hazard SHALL be 1 iff the EXE slot matches or the MEM slot matches.
REQ-021 hazard SHALL be forced to 0 while flush=1, since the squashed instruction needs no stall.
REQ-022 src2 SHALL be ignored for matching when two_src=0, including when src2 equals a pending destination.
REQ-023 A slot with wb_en=0 SHALL never match, regardless of its dest value.
REQ-024 stall_count SHALL increment by 1 on each edge where hazard=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-025 Outputs SHALL reflect slot contents with zero added latency: hazard in the same cycle, slot outputs registered.
REQ-026 Sustained stalls SHALL drain: after one bubble enters EXE, a dependency on the MEM slot clears within two edges.

Reset
REQ-027 While rst=1 at an edge, both slots SHALL clear to all-zero and stall_count SHALL clear to 0, overriding flush and hazard.
REQ-028 Reset asserted mid-stall SHALL leave hazard=0 on the cycle after reset, provided no new match exists.

Configuration
REQ-029 Macro FORWARDING_EN SHALL select the forwarding mode; when it is defined, a forwarding unit is assumed to supply EXE and MEM results.
REQ-030 With FORWARDING_EN defined, hazard SHALL be 1 only on a load-use hazard: EXE slot matches and EXE mem_read=1.
REQ-031 With FORWARDING_EN defined, MEM-slot matches and non-load EXE matches SHALL NOT stall.
REQ-032 Without FORWARDING_EN, REQ-020 SHALL apply and mem_read is stored but not used for the hazard decision.

Verification
REQ-033 Scenario: reset, then ADD R1 (id_wb_en=1, id_dest=1), then next-cycle src1=1 -> without FORWARDING_EN hazard=1 for 2 cycles, then 0; stall_count=2.
REQ-034 Scenario: same as REQ-033 with FORWARDING_EN defined -> hazard=0 throughout; stall_count=0.
REQ-035 Scenario: LDR R3, then next-cycle src2=3 with two_src=1 -> with FORWARDING_EN, hazard=1 for exactly 1 cycle.
REQ-036 Scenario: repeat REQ-035 with two_src=0 -> hazard=0.
REQ-037 Scenario: producer to R5 with flush=1 in the same cycle, followed by a reader of R5 -> EXE slot holds a bubble and hazard=0.
REQ-038 Scenario: force a continuous match for 70000 cycles -> stall_count holds 16'hFFFF; then pulse rst -> stall_count=0 and both slots zero on the next cycle.
